matrix_ls_responder: RTL and testbench
======================================

// Module: matrix_ls_responder
// PURPOSE
// - Scratchpad-side responder for the matrix load/store FU's request interface (ls/rd/imm/address/stride).
// - Buffers requests; turns each into ROWS row accesses on the scratchpad memory port.
// - Loads: writes returned rows into matrix register md. Stores: reads rows of ms and writes them to memory.
// - Returns a one-cycle done (with rd and ls) to the FU and issue logic.
// PARAMETERS
// ROWS        4    rows per matrix; one memory access per row
// ELEM_W      16   element width in bits; ROW_W = ROWS*ELEM_W (localparam)
// FIFO_DEPTH  2    request buffer entries (power of 2)
// PORTS
// CLK             in   1      clock
// RST             in   1      async active-high reset
// req_valid       in   1      FU request valid
// req_ready       out  1      buffer can accept (= !full)
// req_ls          in   2      {load,store}: 2'b10 load, 2'b01 store
// req_rd          in   4      matrix register to load into / store from
// req_imm         in   11     signed immediate offset
// req_addr        in   32     base address
// req_stride      in   32     byte stride between rows
// mem_req_valid   out  1      row access valid
// mem_req_ready   in   1      memory accepts access this cycle
// mem_req_wen     out  1      1 = write (store), 0 = read (load)
// mem_req_addr    out  32     row address
// mem_req_wdata   out  ROW_W  store row data
// mem_rsp_valid   in   1      load row data valid
// mem_rsp_rdata   in   ROW_W  load row data
// mreg_raddr      out  4      matrix reg read select (store)
// mreg_rrow       out  2      row select; mreg_rdata combinational same cycle
// mreg_rdata      in   ROW_W  matrix reg row data
// mreg_wen        out  1      matrix reg row write enable (load)
// mreg_waddr      out  4      matrix reg write select
// mreg_wrow       out  2      row written
// mreg_wdata      out  ROW_W  row write data
// done            out  1      one-cycle completion pulse
// done_rd         out  4      rd of completed request (valid with done)
// done_ls         out  2      ls of completed request (valid with done)
// done_err        out  1      illegal ls (00/11), valid with done
// BEHAVIOUR
// - Reset: FIFO empty, FSM IDLE, row counter 0; all outputs 0 except req_ready=1.
// - FIFO: push on req_valid&&req_ready; pop on the cycle done is asserted. No same-cycle bypass when full.
// - Row r address = req_addr + sext(req_imm) + r*req_stride, computed mod 2^32.
// - FSM:
//   IDLE -> ISSUE when FIFO non-empty (head latched); illegal ls -> DONE with err, no memory traffic.
//   ISSUE: mem_req_valid=1. Addr, wen, wdata held stable until mem_req_ready.
//     Store: wdata = mreg_rdata(rd, r). On accept: r++, or DONE if r==ROWS-1.
//     Load: on accept -> WAIT_RSP.
//   WAIT_RSP: on mem_rsp_valid: mreg_wen=1 with row r, data = rdata. Then r++ -> ISSUE, or DONE after the last row.
//   DONE: done=1 for one cycle, pop, r=0 -> IDLE.
// - Latency with ready/rsp always 1 in the next cycle: store = ROWS+2 cycles from IDLE-with-entry to done.
//   Load = 2*ROWS+2 cycles.
// - mem_rsp_valid outside WAIT_RSP is ignored (covers stale responses after reset).
// - Reset mid-op: request dropped, no done, no further mreg/mem writes.
// - Requests complete strictly in FIFO order.
// STRUCTURE
// - datapath_pkg: mls_state_e {IDLE,ISSUE,WAIT_RSP,DONE}; mls_req_t {ls,rd,imm,addr,stride}.
//   LS_LOAD=2'b10 and LS_STORE=2'b01 constants also go in datapath_pkg.
// - Sub-module mls_req_fifo (depth FIFO_DEPTH of mls_req_t, push/pop/full/empty).
// - Address: running row address register (base+sext(imm), += stride per row); no multiplier.
// TESTING
// - Store rd=3, addr=0x1000, imm=0x10, stride=0x40, ready=1:
//   writes at 0x1010/0x1050/0x1090/0x10D0 with mreg rows 0..3 of m3; done_rd=3 at cycle 6.
// - Load rd=5, addr=0x2000, imm=-4 (0x7FC), stride=8, rsp 1 cycle later:
//   reads at 0x1FFC/0x2004/0x200C/0x2014; mreg m5 rows 0..3 written; done at cycle 10.
// - mem_req_ready low 3 cycles on row 1: addr/wdata stable, no counter advance, done delayed 3 cycles.
// - Three back-to-back requests (depth 2): req_ready drops after 2 pushes.
//   Three dones in push order with matching done_rd.
// - req_ls=2'b11: no mem_req_valid; done=1, done_err=1 two cycles after push.
// - RST asserted in WAIT_RSP, then stray mem_rsp_valid: outputs 0, no mreg_wen, no done; req_ready=1.
// - Address wrap: addr=0xFFFFFFF0, stride=0x10 -> row 1 address 0x00000000.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and constants for the matrix load/store responder.
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        DONE
    } mls_state_e;

    typedef struct packed {
        logic [1:0]  ls;
        logic [3:0]  rd;
        logic [10:0] imm;
        logic [31:0] addr;
        logic [31:0] stride;
    } mls_req_t;

    localparam logic [1:0] LS_LOAD  = 2'b10;
    localparam logic [1:0] LS_STORE = 2'b01;

    function automatic logic ls_legal(input logic [1:0] ls);
        return (ls == LS_LOAD) || (ls == LS_STORE);
    endfunction

    // Row 0 address: base plus sign-extended 11-bit immediate, wrapping mod 2^32.
    function automatic logic [31:0] row_base(input mls_req_t req);
        return req.addr + {{21{req.imm[10]}}, req.imm};
    endfunction

endpackage

// File: rtl/mls_req_fifo.sv
// Request buffer for the responder; DEPTH must be a power of two (>= 2).
module mls_req_fifo
    import datapath_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  mls_req_t push_data,
    input  logic     pop,
    output mls_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    mls_req_t   entries [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            entries[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head  = entries[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/matrix_ls_responder.sv
// Scratchpad-side responder: turns buffered matrix load/store requests into
// per-row memory accesses and matrix register row reads/writes.
module matrix_ls_responder
    import datapath_pkg::*;
#(
    parameter  int ROWS       = 4,
    parameter  int ELEM_W     = 16,
    parameter  int FIFO_DEPTH = 2,
    localparam int ROW_W      = ROWS * ELEM_W,
    localparam int RW         = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_ls,
    input  logic [3:0]       req_rd,
    input  logic [10:0]      req_imm,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_stride,

    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_wen,
    output logic [31:0]      mem_req_addr,
    output logic [ROW_W-1:0] mem_req_wdata,
    input  logic             mem_rsp_valid,
    input  logic [ROW_W-1:0] mem_rsp_rdata,

    output logic [3:0]       mreg_raddr,
    output logic [RW-1:0]    mreg_rrow,
    input  logic [ROW_W-1:0] mreg_rdata,
    output logic             mreg_wen,
    output logic [3:0]       mreg_waddr,
    output logic [RW-1:0]    mreg_wrow,
    output logic [ROW_W-1:0] mreg_wdata,

    output logic             done,
    output logic [3:0]       done_rd,
    output logic [1:0]       done_ls,
    output logic             done_err
);

    mls_state_e  state;
    mls_state_e  next_state;
    mls_req_t    cur;
    mls_req_t    fifo_head;
    mls_req_t    push_req;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [RW-1:0] row;
    logic [31:0] row_addr;
    logic        row_last;
    logic        cur_store;

    assign push_req = '{ls: req_ls, rd: req_rd, imm: req_imm, addr: req_addr, stride: req_stride};
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;
    assign fifo_pop  = (state == DONE);
    assign row_last  = (row == RW'(ROWS - 1));
    assign cur_store = (cur.ls == LS_STORE);

    // The entry stays at the FIFO head until its done pulse, which keeps completions in push order.
    mls_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(push_req),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = ls_legal(fifo_head.ls) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    if (cur_store) begin
                        next_state = row_last ? DONE : ISSUE;
                    end else begin
                        next_state = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    next_state = row_last ? DONE : ISSUE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Running row address replaces a row*stride multiply; it advances on every accepted access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= '0;
            row      <= '0;
            row_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur      <= fifo_head;
                        row      <= '0;
                        row_addr <= row_base(fifo_head);
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        row_addr <= row_addr + cur.stride;
                        if (cur_store) begin
                            row <= row + RW'(1);
                        end
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        row <= row + RW'(1);
                    end
                end
                DONE:    row <= '0;
                default: row <= '0;
            endcase
        end
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_wen   = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mreg_raddr    = '0;
        mreg_rrow     = '0;
        mreg_wen      = 1'b0;
        mreg_waddr    = '0;
        mreg_wrow     = '0;
        mreg_wdata    = '0;
        done          = 1'b0;
        done_rd       = '0;
        done_ls       = '0;
        done_err      = 1'b0;
        unique case (state)
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = cur_store;
                mem_req_addr  = row_addr;
                if (cur_store) begin
                    mreg_raddr    = cur.rd;
                    mreg_rrow     = row;
                    mem_req_wdata = mreg_rdata;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    mreg_wen   = 1'b1;
                    mreg_waddr = cur.rd;
                    mreg_wrow  = row;
                    mreg_wdata = mem_rsp_rdata;
                end
            end
            DONE: begin
                done     = 1'b1;
                done_rd  = cur.rd;
                done_ls  = cur.ls;
                done_err = !ls_legal(cur.ls);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_ls_responder.sv
// Directed bench for matrix_ls_responder: table of single requests plus
// back-to-back, stall and mid-operation reset sequences.
module tb_matrix_ls_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_ls;
    logic [3:0]  req_rd;
    logic [10:0] req_imm;
    logic [31:0] req_addr;
    logic [31:0] req_stride;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic [3:0]  mreg_raddr;
    logic [1:0]  mreg_rrow;
    logic [63:0] mreg_rdata;
    logic        mreg_wen;
    logic [3:0]  mreg_waddr;
    logic [1:0]  mreg_wrow;
    logic [63:0] mreg_wdata;
    logic        done;
    logic [3:0]  done_rd;
    logic [1:0]  done_ls;
    logic        done_err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [1:0]       ls;
        logic [3:0]       rd;
        logic [10:0]      imm;
        logic [31:0]      addr;
        logic [31:0]      stride;
        int               stall_row;
        int               stall_cycles;
        logic [3:0][31:0] exp_addr;
        int               exp_done;
        logic             exp_err;
    } vec_t;

    vec_t vecs [8];

    matrix_ls_responder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_ls       (req_ls),
        .req_rd       (req_rd),
        .req_imm      (req_imm),
        .req_addr     (req_addr),
        .req_stride   (req_stride),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_wen  (mem_req_wen),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .mreg_raddr   (mreg_raddr),
        .mreg_rrow    (mreg_rrow),
        .mreg_rdata   (mreg_rdata),
        .mreg_wen     (mreg_wen),
        .mreg_waddr   (mreg_waddr),
        .mreg_wrow    (mreg_wrow),
        .mreg_wdata   (mreg_wdata),
        .done         (done),
        .done_rd      (done_rd),
        .done_ls      (done_ls),
        .done_err     (done_err)
    );

    always #5 clk = ~clk;

    // Matrix register file model: each row word encodes its register and row number.
    assign mreg_rdata = {4{8'h5A, 2'b00, mreg_rrow, mreg_raddr}};

    function automatic logic [63:0] exp_store_row(input logic [3:0] rd, input int r);
        logic [1:0] rr;
        rr = 2'(r);
        return {4{8'h5A, 2'b00, rr, rd}};
    endfunction

    function automatic vec_t make_vec(input logic [1:0] ls, input logic [3:0] rd,
                                      input logic [10:0] imm, input logic [31:0] addr,
                                      input logic [31:0] stride, input int stall_row,
                                      input int stall_cycles, input logic [31:0] a0,
                                      input logic [31:0] a1, input logic [31:0] a2,
                                      input logic [31:0] a3, input int exp_done,
                                      input logic exp_err);
        vec_t v;
        v.ls           = ls;
        v.rd           = rd;
        v.imm          = imm;
        v.addr         = addr;
        v.stride       = stride;
        v.stall_row    = stall_row;
        v.stall_cycles = stall_cycles;
        v.exp_addr[0]  = a0;
        v.exp_addr[1]  = a1;
        v.exp_addr[2]  = a2;
        v.exp_addr[3]  = a3;
        v.exp_done     = exp_done;
        v.exp_err      = exp_err;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Push one request, then act as memory (ready except during a stall, read data one cycle after accept).
    task automatic apply_stimulus(input int idx, input vec_t v);
        int          acc        = 0;
        int          wr         = 0;
        int          stall_left = v.stall_cycles;
        logic        pend       = 1'b0;
        logic [31:0] paddr      = '0;
        logic        seen       = 1'b0;
        logic        is_store   = (v.ls == 2'b01);
        logic        is_load    = (v.ls == 2'b10);

        @(negedge clk);
        req_valid     = 1'b1;
        req_ls        = v.ls;
        req_rd        = v.rd;
        req_imm       = v.imm;
        req_addr      = v.addr;
        req_stride    = v.stride;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        #1;
        check_output($sformatf("vec%0d_req_ready", idx), 64'(req_ready), 64'd1);

        for (int n = 1; n <= 60 && !seen; n++) begin
            @(negedge clk);
            req_valid     = 1'b0;
            mem_req_ready = !(stall_left > 0 && acc == v.stall_row);
            mem_rsp_valid = pend;
            mem_rsp_rdata = pend ? {paddr, ~paddr} : 64'd0;
            pend          = 1'b0;
            #1;
            if (mem_req_valid) begin
                if (acc < 4) begin
                    check_output($sformatf("vec%0d_row%0d_addr", idx, acc),
                                 64'(mem_req_addr), 64'(v.exp_addr[acc]));
                    check_output($sformatf("vec%0d_row%0d_wen", idx, acc),
                                 64'(mem_req_wen), 64'(is_store));
                    if (is_store) begin
                        check_output($sformatf("vec%0d_row%0d_wdata", idx, acc),
                                     mem_req_wdata, exp_store_row(v.rd, acc));
                    end
                end
                if (mem_req_ready) begin
                    if (!is_store) begin
                        pend  = 1'b1;
                        paddr = mem_req_addr;
                    end
                    acc++;
                end else begin
                    stall_left--;
                end
            end
            if (mreg_wen) begin
                if (wr < 4) begin
                    check_output($sformatf("vec%0d_mreg%0d_waddr", idx, wr),
                                 64'(mreg_waddr), 64'(v.rd));
                    check_output($sformatf("vec%0d_mreg%0d_wrow", idx, wr),
                                 64'(mreg_wrow), 64'(wr));
                    check_output($sformatf("vec%0d_mreg%0d_wdata", idx, wr),
                                 mreg_wdata, {v.exp_addr[wr], ~v.exp_addr[wr]});
                end
                wr++;
            end
            if (done) begin
                seen = 1'b1;
                check_output($sformatf("vec%0d_done_cycle", idx), 64'(n), 64'(v.exp_done));
                check_output($sformatf("vec%0d_done_rd", idx), 64'(done_rd), 64'(v.rd));
                check_output($sformatf("vec%0d_done_ls", idx), 64'(done_ls), 64'(v.ls));
                check_output($sformatf("vec%0d_done_err", idx), 64'(done_err), 64'(v.exp_err));
            end
        end
        check_output($sformatf("vec%0d_done_seen", idx), 64'(seen), 64'd1);
        check_output($sformatf("vec%0d_mem_accesses", idx), 64'(acc), v.exp_err ? 64'd0 : 64'd4);
        check_output($sformatf("vec%0d_mreg_writes", idx), 64'(wr), is_load ? 64'd4 : 64'd0);
    endtask

    initial begin
        logic [3:0] b2b_rd [3];
        int pushed;
        int dones;

        req_valid     = 1'b0;
        req_ls        = '0;
        req_rd        = '0;
        req_imm       = '0;
        req_addr      = '0;
        req_stride    = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;

        vecs[0] = make_vec(2'b01, 4'd3, 11'h010, 32'h0000_1000, 32'h40, 0, 0,
                           32'h1010, 32'h1050, 32'h1090, 32'h10D0, 6, 1'b0);
        vecs[1] = make_vec(2'b10, 4'd5, 11'h7FC, 32'h0000_2000, 32'h8, 0, 0,
                           32'h1FFC, 32'h2004, 32'h200C, 32'h2014, 10, 1'b0);
        vecs[2] = make_vec(2'b01, 4'd3, 11'h010, 32'h0000_1000, 32'h40, 1, 3,
                           32'h1010, 32'h1050, 32'h1090, 32'h10D0, 9, 1'b0);
        vecs[3] = make_vec(2'b01, 4'hA, 11'h000, 32'hFFFF_FFF0, 32'h10, 0, 0,
                           32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0010, 32'h0000_0020, 6, 1'b0);
        vecs[4] = make_vec(2'b11, 4'd6, 11'h000, 32'h0000_5000, 32'h4, 0, 0,
                           32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1);
        vecs[5] = make_vec(2'b00, 4'd9, 11'h000, 32'h0000_6000, 32'h4, 0, 0,
                           32'h0, 32'h0, 32'h0, 32'h0, 2, 1'b1);
        vecs[6] = make_vec(2'b10, 4'hF, 11'h3FF, 32'h8000_0000, 32'hFFFF_FF00, 2, 2,
                           32'h8000_03FF, 32'h8000_02FF, 32'h8000_01FF, 32'h8000_00FF, 12, 1'b0);
        vecs[7] = make_vec(2'b10, 4'd1, 11'h400, 32'h0000_0400, 32'h4, 0, 0,
                           32'h0, 32'h4, 32'h8, 32'hC, 10, 1'b0);

        // Reset state, with a stray response present to show it is ignored.
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_ctrl_outputs",
                     64'({mem_req_valid, mem_req_wen, mem_req_addr, mreg_wen, mreg_waddr,
                          mreg_wrow, mreg_raddr, mreg_rrow, done, done_rd, done_ls, done_err}),
                     64'd0);
        check_output("reset_data_outputs", mem_req_wdata | mreg_wdata, 64'd0);
        check_output("reset_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst           = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        #1;
        check_output("post_reset_idle", 64'({mem_req_valid, mreg_wen, done, req_ready}), 64'b0001);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Three back-to-back stores into a two-entry buffer.
        b2b_rd[0] = 4'd1;
        b2b_rd[1] = 4'd2;
        b2b_rd[2] = 4'd7;
        pushed = 0;
        dones  = 0;
        for (int n = 0; n < 80 && dones < 3; n++) begin
            @(negedge clk);
            req_valid     = (pushed < 3);
            req_ls        = 2'b01;
            req_rd        = (pushed < 3) ? b2b_rd[pushed] : 4'd0;
            req_imm       = '0;
            req_addr      = 32'h0000_4000;
            req_stride    = 32'h4;
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b0;
            #1;
            if (n == 2) begin
                check_output("b2b_ready_drops_when_full", 64'(req_ready), 64'd0);
            end
            if (req_valid && req_ready) begin
                pushed++;
            end
            if (done) begin
                if (dones < 3) begin
                    check_output($sformatf("b2b_done%0d_rd", dones), 64'(done_rd), 64'(b2b_rd[dones]));
                end
                dones++;
            end
        end
        check_output("b2b_push_count", 64'(pushed), 64'd3);
        check_output("b2b_done_count", 64'(dones), 64'd3);

        // Reset while waiting for a load response, then a stray response.
        @(negedge clk);
        req_valid     = 1'b1;
        req_ls        = 2'b10;
        req_rd        = 4'd4;
        req_imm       = '0;
        req_addr      = 32'h0000_3000;
        req_stride    = 32'h20;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        check_output("rst_test_issue_seen", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("rst_mid_op_outputs", 64'({mem_req_valid, mreg_wen, done, req_ready}), 64'b0001);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst           = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
            #1;
            check_output($sformatf("rst_stray_rsp_quiet%0d", k),
                         64'({mem_req_valid, mreg_wen, done, req_ready}), 64'b0001);
            check_output($sformatf("rst_stray_rsp_wdata%0d", k), mreg_wdata, 64'd0);
        end
        mem_rsp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
